// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter
//   Drives the single GRF write port. The in-order W stage has priority.
//   MDU results are buffered in a small FIFO and commit only on cycles the
//   W stage leaves free. A 32-bit pending scoreboard tracks registers with
//   an MDU result still in flight, so the D stage can stall on them.
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   wb_we/wb_addr/wb_data        W-stage write request (cannot be stalled)
//   md_valid/md_addr/md_data     MDU result, accepted when md_ready
//   md_ready                     FIFO not full (pre-edge occupancy)
//   iss_valid/iss_addr           D stage issues a long-latency op
//   qry_addr1/2, qry_busy1/2     scoreboard lookups for rs/rt
//   grf_we/grf_addr/grf_data     GRF write port
//   fifo_cnt                     FIFO occupancy, 0..DEPTH
//   err                          sticky protocol error (WAW issue, pop of non-pending reg)
module grf_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_we,
  input  logic [4:0]    wb_addr,
  input  logic [31:0]   wb_data,
  input  logic          md_valid,
  input  logic [4:0]    md_addr,
  input  logic [31:0]   md_data,
  output logic          md_ready,
  input  logic          iss_valid,
  input  logic [4:0]    iss_addr,
  input  logic [4:0]    qry_addr1,
  input  logic [4:0]    qry_addr2,
  output logic          qry_busy1,
  output logic          qry_busy2,
  output logic          grf_we,
  output logic [4:0]    grf_addr,
  output logic [31:0]   grf_data,
  output logic [AW:0]   fifo_cnt,
  output logic          err
);

  logic [4:0]    mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [31:0]   busy;
  logic [31:0]   busy_nxt;

  logic          wb_req;
  logic          push;
  logic          pop;
  logic          iss_set;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;
  logic          err_set;

  assign wb_req    = wb_we && (wb_addr != 5'd0);
  assign md_ready  = (cnt != (AW+1)'(DEPTH));
  assign push      = md_valid && md_ready;
  assign pop       = !wb_req && (cnt != '0);
  assign iss_set   = iss_valid && (iss_addr != 5'd0);
  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign fifo_cnt  = cnt;

  // No same-cycle bypass: a query sees only what was issued on earlier cycles.
  assign qry_busy1 = busy[qry_addr1] && (qry_addr1 != 5'd0);
  assign qry_busy2 = busy[qry_addr2] && (qry_addr2 != 5'd0);

  always_comb begin
    grf_we   = 1'b0;
    grf_addr = 5'd0;
    grf_data = 32'd0;
    if (wb_req) begin
      grf_we   = 1'b1;
      grf_addr = wb_addr;
      grf_data = wb_data;
    end else if (pop) begin
      // $0 results still drain through the FIFO but never write the GRF
      grf_we   = (head_addr != 5'd0);
      grf_addr = head_addr;
      grf_data = head_data;
    end
  end

  // Set is applied after clear so a re-issue in the commit cycle stays pending.
  always_comb begin
    busy_nxt = busy;
    if (pop && (head_addr != 5'd0)) busy_nxt[head_addr] = 1'b0;
    if (iss_set) busy_nxt[iss_addr] = 1'b1;
  end

  assign err_set = (iss_set && busy[iss_addr]) ||
                   (pop && (head_addr != 5'd0) && !busy[head_addr]);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= md_addr;
      mem_data[wr_ptr] <= md_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      busy   <= '0;
      err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + (AW+1)'(1);
      else if (pop && !push) cnt <= cnt - (AW+1)'(1);
      busy <= busy_nxt;
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed bench for grf_write_arbiter. Inputs change 1 ns after a rising
// edge; combinational outputs are checked 3 ns later, well before the next edge.
module tb_grf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_ready;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [4:0]  qry_addr1;
  logic [4:0]  qry_addr2;
  logic        qry_busy1;
  logic        qry_busy2;
  logic        grf_we;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data;
  logic [2:0]  fifo_cnt;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  grf_write_arbiter #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .qry_addr1(qry_addr1), .qry_addr2(qry_addr2),
    .qry_busy1(qry_busy1), .qry_busy2(qry_busy2),
    .grf_we(grf_we), .grf_addr(grf_addr), .grf_data(grf_data),
    .fifo_cnt(fifo_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    wb_we = 0; wb_addr = 0; wb_data = 0;
    md_valid = 0; md_addr = 0; md_data = 0;
    iss_valid = 0; iss_addr = 0;
  endtask

  initial begin
    idle();
    qry_addr1 = 0; qry_addr2 = 0;
    reset = 1;
    cyc(); cyc();
    reset = 0;
    settle();
    chk("rst_grf_we",   32'(grf_we), 0);
    chk("rst_grf_addr", 32'(grf_addr), 0);
    chk("rst_grf_data", grf_data, 0);
    chk("rst_cnt",      32'(fifo_cnt), 0);
    chk("rst_ready",    32'(md_ready), 1);
    chk("rst_err",      32'(err), 0);

    // 1: issue $5, MDU result one cycle later, commit the cycle after push
    cyc();
    iss_valid = 1; iss_addr = 5; qry_addr1 = 5; qry_addr2 = 6;
    settle();
    chk("t1_no_bypass", 32'(qry_busy1), 0);
    cyc();
    iss_valid = 0;
    md_valid = 1; md_addr = 5; md_data = 32'h1234;
    settle();
    chk("t1_busy_set", 32'(qry_busy1), 1);
    chk("t1_busy2_clr", 32'(qry_busy2), 0);
    chk("t1_no_same_cyc", 32'(grf_we), 0);
    cyc();
    md_valid = 0;
    settle();
    chk("t1_we",   32'(grf_we), 1);
    chk("t1_addr", 32'(grf_addr), 5);
    chk("t1_data", grf_data, 32'h1234);
    chk("t1_cnt",  32'(fifo_cnt), 1);
    chk("t1_busy_held", 32'(qry_busy1), 1);
    cyc();
    settle();
    chk("t1_busy_done", 32'(qry_busy1), 0);
    chk("t1_cnt0", 32'(fifo_cnt), 0);
    chk("t1_idle_we", 32'(grf_we), 0);

    // 2: MDU head $6 waits behind three W-stage writes to $7
    iss_valid = 1; iss_addr = 6;
    cyc();
    iss_valid = 0;
    md_valid = 1; md_addr = 6; md_data = 32'h66;
    wb_we = 1; wb_addr = 7; wb_data = 32'hAA;
    cyc();
    md_valid = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t2_wb_we",   32'(grf_we), 1);
      chk("t2_wb_addr", 32'(grf_addr), 7);
      chk("t2_wb_data", grf_data, 32'hAA);
      chk("t2_cnt_hold", 32'(fifo_cnt), 1);
      cyc();
    end
    wb_we = 0; wb_addr = 0; wb_data = 0;
    settle();
    chk("t2_md_we",   32'(grf_we), 1);
    chk("t2_md_addr", 32'(grf_addr), 6);
    chk("t2_md_data", grf_data, 32'h66);
    cyc();
    settle();
    chk("t2_cnt0", 32'(fifo_cnt), 0);

    // 3: fill the FIFO while the W stage occupies the port
    for (int i = 0; i < 4; i++) begin
      iss_valid = 1; iss_addr = 5'(10 + i);
      cyc();
    end
    iss_valid = 0;
    wb_we = 1; wb_addr = 1; wb_data = 32'h1;
    for (int i = 0; i < 4; i++) begin
      md_valid = 1; md_addr = 5'(10 + i); md_data = 32'h100 + i;
      settle();
      chk("t3_ready", 32'(md_ready), 1);
      cyc();
    end
    md_addr = 14; md_data = 32'hBAD;
    settle();
    chk("t3_full_cnt", 32'(fifo_cnt), 4);
    chk("t3_full_ready", 32'(md_ready), 0);
    cyc();
    settle();
    chk("t3_refused", 32'(fifo_cnt), 4);
    // full FIFO pops this cycle but still refuses the pending push
    wb_we = 0; wb_addr = 0; wb_data = 0;
    settle();
    chk("t3_pop0_addr", 32'(grf_addr), 10);
    chk("t3_pop0_data", grf_data, 32'h100);
    cyc();
    md_valid = 0;
    settle();
    chk("t3_pop_refuse", 32'(fifo_cnt), 3);
    for (int i = 1; i < 4; i++) begin
      settle();
      chk("t3_pop_addr", 32'(grf_addr), 32'(10 + i));
      chk("t3_pop_data", grf_data, 32'h100 + i);
      cyc();
    end
    qry_addr1 = 10; qry_addr2 = 13;
    settle();
    chk("t3_empty", 32'(fifo_cnt), 0);
    chk("t3_busy10", 32'(qry_busy1), 0);
    chk("t3_busy13", 32'(qry_busy2), 0);
    chk("t3_err", 32'(err), 0);

    // 4: six entries across a drain; pointers wrap
    for (int i = 0; i < 6; i++) begin
      iss_valid = 1; iss_addr = 5'(16 + i);
      cyc();
    end
    iss_valid = 0;
    wb_we = 1; wb_addr = 2; wb_data = 32'h2;
    for (int i = 0; i < 3; i++) begin
      md_valid = 1; md_addr = 5'(16 + i); md_data = 32'hD000 + i;
      cyc();
    end
    wb_we = 0; wb_addr = 0; wb_data = 0;
    for (int i = 0; i < 3; i++) begin
      md_valid = 1; md_addr = 5'(19 + i); md_data = 32'hD003 + i;
      settle();
      chk("t4_ovl_addr", 32'(grf_addr), 32'(16 + i));
      chk("t4_ovl_data", grf_data, 32'hD000 + i);
      chk("t4_ovl_cnt",  32'(fifo_cnt), 3);
      cyc();
    end
    md_valid = 0;
    for (int i = 3; i < 6; i++) begin
      settle();
      chk("t4_drn_addr", 32'(grf_addr), 32'(16 + i));
      chk("t4_drn_data", grf_data, 32'hD000 + i);
      cyc();
    end
    settle();
    chk("t4_empty", 32'(fifo_cnt), 0);
    chk("t4_err", 32'(err), 0);

    // 5: everything aimed at $0
    wb_we = 1; wb_addr = 0; wb_data = 32'hFF;
    iss_valid = 1; iss_addr = 0;
    md_valid = 1; md_addr = 0; md_data = 32'h55;
    qry_addr1 = 0;
    settle();
    chk("t5_wb0_we",   32'(grf_we), 0);
    chk("t5_wb0_addr", 32'(grf_addr), 0);
    cyc();
    idle();
    settle();
    chk("t5_md0_we",   32'(grf_we), 0);
    chk("t5_md0_data", grf_data, 32'h55);
    chk("t5_cnt",      32'(fifo_cnt), 1);
    chk("t5_busy0",    32'(qry_busy1), 0);
    cyc();
    settle();
    chk("t5_cnt0", 32'(fifo_cnt), 0);
    chk("t5_err",  32'(err), 0);

    // 6: WAW issue sets sticky err; reset clears it and the FIFO
    iss_valid = 1; iss_addr = 9; qry_addr1 = 9;
    cyc();
    settle();
    chk("t6_err_pre", 32'(err), 0);
    cyc();
    iss_valid = 0;
    settle();
    chk("t6_err_set", 32'(err), 1);
    wb_we = 1; wb_addr = 3; wb_data = 32'h3;
    md_valid = 1; md_addr = 9; md_data = 32'h99;
    cyc();
    md_valid = 0;
    settle();
    chk("t6_err_sticky", 32'(err), 1);
    chk("t6_cnt1", 32'(fifo_cnt), 1);
    reset = 1;
    cyc();
    reset = 0;
    idle();
    settle();
    chk("t6_rst_err",  32'(err), 0);
    chk("t6_rst_cnt",  32'(fifo_cnt), 0);
    chk("t6_rst_busy", 32'(qry_busy1), 0);
    chk("t6_rst_we",   32'(grf_we), 0);
    cyc();
    settle();
    chk("t6_after_we", 32'(grf_we), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
